// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, PC-tagged fetch queue, redirect flush.
// Optional macro IFU_STALL_CNT_EN adds a saturating stall_cnt output.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction_word,
  output logic [31:0] inst_pc
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int          AW      = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QUEUE_DEPTH);

  logic [31:0]   pc_r;
  logic [31:0]   pc_q_r   [QUEUE_DEPTH];
  logic [31:0]   data_q_r [QUEUE_DEPTH];
  logic [AW-1:0] head_r;
  logic [AW:0]   count_r;     // allocated entries (filled + awaiting response)
  logic [AW:0]   nfill_r;     // filled entries, contiguous from head
  logic [15:0]   drop_cnt_r;
  logic          run_r;

  logic [AW:0]   outstanding_s;
  logic [AW-1:0] fill_idx_s;
  logic [AW-1:0] tail_idx_s;
  logic          req_fire_s;
  logic          pop_s;
  logic          rsp_drop_s;
  logic          rsp_fill_s;
  logic          rsp_any_s;
  logic [15:0]   drop_next_s;

  // Handshake decode and queue index arithmetic
  always_comb begin
    outstanding_s = count_r - nfill_r;
    fill_idx_s    = head_r + nfill_r[AW-1:0];
    tail_idx_s    = head_r + count_r[AW-1:0];
    req_fire_s    = imem_req_valid && imem_req_ready;
    pop_s         = inst_valid && inst_ready;
    rsp_drop_s    = imem_rsp_valid && (drop_cnt_r != 16'd0);
    rsp_fill_s    = imem_rsp_valid && (drop_cnt_r == 16'd0) && (outstanding_s != {(AW+1){1'b0}});
    rsp_any_s     = rsp_drop_s || rsp_fill_s;
    // Every in-flight response becomes stale on redirect, minus one consumed this cycle.
    drop_next_s   = drop_cnt_r + 16'(outstanding_s) - {15'd0, rsp_any_s};
  end

  assign imem_req_valid   = run_r && (count_r < DEPTH_C) && !redirect_valid;
  assign imem_req_addr    = pc_r;
  assign inst_valid       = (nfill_r != {(AW+1){1'b0}});
  assign instruction_word = data_q_r[head_r];
  assign inst_pc          = pc_q_r[head_r];

  // PC, queue storage, occupancy and drop accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= {RESET_PC[31:2], 2'b00};
      head_r     <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      nfill_r    <= {(AW+1){1'b0}};
      drop_cnt_r <= 16'd0;
      run_r      <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q_r[i]   <= 32'd0;
        data_q_r[i] <= 32'd0;
      end
    end else begin
      run_r <= 1'b1;
      if (redirect_valid) begin
        pc_r       <= redirect_pc & 32'hFFFF_FFFC;
        head_r     <= {AW{1'b0}};
        count_r    <= {(AW+1){1'b0}};
        nfill_r    <= {(AW+1){1'b0}};
        drop_cnt_r <= drop_next_s;
      end else begin
        if (req_fire_s) begin
          pc_q_r[tail_idx_s] <= pc_r;
          pc_r               <= pc_r + 32'd4;
        end
        if (rsp_fill_s) begin
          data_q_r[fill_idx_s] <= imem_rsp_data;
        end
        if (rsp_drop_s) begin
          drop_cnt_r <= drop_cnt_r - 16'd1;
        end
        head_r  <= head_r + {{(AW-1){1'b0}}, pop_s};
        count_r <= count_r + {{AW{1'b0}}, req_fire_s} - {{AW{1'b0}}, pop_s};
        nfill_r <= nfill_r + {{AW{1'b0}}, rsp_fill_s} - {{AW{1'b0}}, pop_s};
      end
    end
  end

`ifdef IFU_STALL_CNT_EN
  // Saturating count of cycles with nothing for the decoder, excluding redirect cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (!inst_valid && !redirect_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: in-order memory model with epoch-tagged requests
// and a stream-level reference (expected PC sequence per fetch epoch).
module tb_inst_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction_word;
  logic [31:0] inst_pc;
`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction_word(instruction_word), .inst_pc(inst_pc)
`ifdef IFU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } req_t;

  req_t        mq[$];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          buffered = 0;
  int          alloc = 0;
  int          acc_cnt = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  logic [31:0] exp_req_pc = 32'd0;
  logic [31:0] exp_out_pc = 32'd0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'd0) return 32'h0042_82B3;
    else if (a == 32'd4) return 32'h4054_0333;
    else return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, advance the model at posedge.
  task automatic cycle(input logic rq, input logic ir, input logic rd, input logic [31:0] rpc);
    logic        fire_req;
    logic        fire_pop;
    logic        rsp;
    logic [31:0] addr;
    imem_req_ready = rq;
    inst_ready     = ir;
    redirect_valid = rd;
    redirect_pc    = rpc;
    rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(mq[0].addr) : $urandom;
    @(negedge clk);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, buffered > 0});
    if (buffered > 0) begin
      chk("inst_pc", inst_pc, exp_out_pc);
      chk("instruction_word", instruction_word, memf(exp_out_pc));
    end
    if (rd) chk("req_valid_on_redirect", {31'd0, imem_req_valid}, 32'd0);
    else if (alloc >= DEPTH) chk("req_valid_when_full", {31'd0, imem_req_valid}, 32'd0);
    else if (cyc > 0) chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
    fire_req = imem_req_valid && rq;
    fire_pop = inst_valid && ir;
    addr     = imem_req_addr;
    @(posedge clk);
    if (rsp) begin
      if (mq[0].ep == epoch) buffered++;
      void'(mq.pop_front());
    end
    if (fire_pop && !rd) begin
      buffered--;
      alloc--;
      exp_out_pc += 32'd4;
    end
    if (fire_req) begin
      mq.push_back('{addr, epoch, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
      exp_req_pc += 32'd4;
      alloc++;
      acc_cnt++;
    end
    if (rd) begin
      epoch++;
      buffered   = 0;
      alloc      = 0;
      exp_req_pc = rpc & 32'hFFFF_FFFC;
      exp_out_pc = rpc & 32'hFFFF_FFFC;
    end
    cyc++;
    #1;
  endtask

  // Assert reset (memory resets with the block), check outputs before any clock edge, release.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    mq.delete();
    epoch++;
    buffered   = 0;
    alloc      = 0;
    exp_req_pc = 32'd0;
    exp_out_pc = 32'd0;
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_instruction_word", instruction_word, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int n0;
    #3;
    // Reset and steady fetch with 1-cycle memory latency
    do_reset();
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Decoder backpressure: exactly DEPTH requests, then resume at 0x8
    do_reset();
    n0 = acc_cnt;
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    chk("bp_accepted", 32'(acc_cnt - n0), 32'(DEPTH));
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Memory stall: address held at 0x0, no output
    do_reset();
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 32'd0);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect to 0x103 with two responses still in flight
    do_reset();
    lat_min = 3;
    lat_max = 3;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    chk("inflight_before_redirect", 32'(mq.size()), 32'd2);
    lat_min = 0;
    lat_max = 0;
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect coincident with a response, then a redirect into the PC wrap point
    do_reset();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF9);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    // Randomized traffic: ready jitter, variable latency, occasional redirects
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
            $urandom_range(15, 0) == 0, $urandom);
    end

    // Asynchronous reset pulsed between edges mid-burst
    lat_min = 0;
    lat_max = 0;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'd0);
    #2;
    do_reset();
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
